fifo_param: RTL and testbench

// - Parametrised synchronous FIFO with programmable almost-full/almost-empty thresholds,

---
 rtl/fifo_param.sv | 148 ++++++++++++++
 tb/tb_fifo_param.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy FSM, programmable almost thresholds and sticky error.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is a registered 1-cycle read.
module fifo_param #(
   parameter int DATA_WIDTH = 6,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic                  write,
   input  logic                  read,
   input  logic [DATA_WIDTH-1:0] buff_in,
   input  logic [ADDR_WIDTH:0]   umb_almost_full,
   input  logic [ADDR_WIDTH:0]   umb_almost_empty,
   input  logic                  error_clr,
   output logic [DATA_WIDTH-1:0] buff_out,
   output logic                  valid,
   output logic                  fifo_full,
   output logic                  fifo_empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   data_count,
   output logic                  error
);

   localparam int                  DEPTH     = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0] CNT_ZERO  = (ADDR_WIDTH+1)'(0);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = ADDR_WIDTH'(0);

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_FULL    = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]     count_q, count_d;
   logic                    almost_full_q, almost_empty_q;
   logic                    error_q, error_d;
   logic                    rd_ok_s, wr_ok_s, err_set_s;
   logic                    fifo_full_s, fifo_empty_s;

   assign fifo_full_s  = (state_q == ST_FULL);
   assign fifo_empty_s = (state_q == ST_EMPTY);

   // Acceptance, next occupancy, next FSM state and sticky-error update
   always_comb begin
      rd_ok_s   = read & ~fifo_empty_s;
      // A push on full is accepted when paired with a pop: the freed slot takes the new word.
      wr_ok_s   = write & (~fifo_full_s | read);
      err_set_s = (write & fifo_full_s & ~read) | (read & fifo_empty_s);
      count_d   = count_q;
      state_d   = state_q;
      error_d   = error_q;
      wr_ptr_d  = wr_ok_s ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d  = rd_ok_s ? rd_ptr_q + PTR_ONE : rd_ptr_q;

      case ({wr_ok_s, rd_ok_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      case (state_q)
         ST_EMPTY: begin
            if (wr_ok_s && !rd_ok_s) state_d = ST_PARTIAL;
            else                     state_d = ST_EMPTY;
         end
         ST_PARTIAL: begin
            if (count_d == DEPTH_CNT)     state_d = ST_FULL;
            else if (count_d == CNT_ZERO) state_d = ST_EMPTY;
            else                          state_d = ST_PARTIAL;
         end
         ST_FULL: begin
            if (rd_ok_s && !wr_ok_s) state_d = ST_PARTIAL;
            else                     state_d = ST_FULL;
         end
         default: state_d = ST_EMPTY;
      endcase

      if (err_set_s)      error_d = 1'b1;
      else if (error_clr) error_d = 1'b0;
      else                error_d = error_q;
   end

   // Storage array, intentionally not reset
   always_ff @(posedge clk) begin
      if (wr_ok_s) mem_q[wr_ptr_q] <= buff_in;
      else         mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
   end

   // Occupancy FSM, pointers, count and registered status flags
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q        <= ST_EMPTY;
         wr_ptr_q       <= PTR_ZERO;
         rd_ptr_q       <= PTR_ZERO;
         count_q        <= CNT_ZERO;
         almost_full_q  <= 1'b0;
         almost_empty_q <= 1'b0;
         error_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         almost_full_q  <= (count_d >= umb_almost_full);
         almost_empty_q <= (count_d <= umb_almost_empty);
         error_q        <= error_d;
      end
   end

`ifdef FIFO_FWFT_EN
   assign buff_out = fifo_empty_s ? {DATA_WIDTH{1'b0}} : mem_q[rd_ptr_q];
   assign valid    = ~fifo_empty_s;
`else
   logic [DATA_WIDTH-1:0] buff_out_q;
   logic                  valid_q;

   // Registered read port: data and a one-cycle valid pulse follow each accepted pop
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         buff_out_q <= {DATA_WIDTH{1'b0}};
         valid_q    <= 1'b0;
      end else begin
         if (rd_ok_s) buff_out_q <= mem_q[rd_ptr_q];
         else         buff_out_q <= buff_out_q;
         valid_q <= rd_ok_s;
      end
   end

   assign buff_out = buff_out_q;
   assign valid    = valid_q;
`endif

   assign fifo_full    = fifo_full_s;
   assign fifo_empty   = fifo_empty_s;
   assign almost_full  = almost_full_q;
   assign almost_empty = almost_empty_q;
   assign data_count   = count_q;
   assign error        = error_q;

endmodule

// File: tb/tb_fifo_param.sv
// Scoreboard bench for fifo_param: a queue model of stored words plus count/flag/error model.
module tb_fifo_param;

   localparam int DW    = 6;
   localparam int AW    = 3;
   localparam int DEPTH = 8;
   localparam int AF    = 6;
   localparam int AE    = 3;

   logic          clk;
   logic          reset_L;
   logic          write;
   logic          read;
   logic [DW-1:0] buff_in;
   logic [AW:0]   umb_almost_full;
   logic [AW:0]   umb_almost_empty;
   logic          error_clr;
   logic [DW-1:0] buff_out;
   logic          valid;
   logic          fifo_full;
   logic          fifo_empty;
   logic          almost_full;
   logic          almost_empty;
   logic [AW:0]   data_count;
   logic          error;

   int            n_checks;
   int            n_pass;
   int            m_count;
   logic          m_err;
   logic [DW-1:0] sb_q [$];

   fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk              (clk),
      .reset_L          (reset_L),
      .write            (write),
      .read             (read),
      .buff_in          (buff_in),
      .umb_almost_full  (umb_almost_full),
      .umb_almost_empty (umb_almost_empty),
      .error_clr        (error_clr),
      .buff_out         (buff_out),
      .valid            (valid),
      .fifo_full        (fifo_full),
      .fifo_empty       (fifo_empty),
      .almost_full      (almost_full),
      .almost_empty     (almost_empty),
      .data_count       (data_count),
      .error            (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // One clock: drive at negedge, update model, compare 1 time unit after posedge
   task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d, input logic clr);
      logic          rd_ok;
      logic          wr_ok;
      logic          set;
      logic [DW-1:0] head;
      @(negedge clk);
      write = w; read = r; buff_in = d; error_clr = clr;
      rd_ok = r && (m_count != 0);
      wr_ok = w && ((m_count != DEPTH) || r);
      set   = (w && (m_count == DEPTH) && !r) || (r && (m_count == 0));
      head  = '0;
      if (rd_ok) head = sb_q.pop_front();
      if (wr_ok) sb_q.push_back(d);
      m_count = m_count + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
      m_err   = set ? 1'b1 : (clr ? 1'b0 : m_err);
      @(posedge clk);
      #1;
      check_eq("data_count",   int'(data_count),   m_count);
      check_eq("fifo_full",    int'(fifo_full),    int'(m_count == DEPTH));
      check_eq("fifo_empty",   int'(fifo_empty),   int'(m_count == 0));
      check_eq("almost_full",  int'(almost_full),  int'(m_count >= AF));
      check_eq("almost_empty", int'(almost_empty), int'(m_count <= AE));
      check_eq("error",        int'(error),        int'(m_err));
`ifdef FIFO_FWFT_EN
      check_eq("valid_fwft", int'(valid), int'(m_count != 0));
      if (m_count != 0) check_eq("head_fwft", int'(buff_out), int'(sb_q[0]));
`else
      check_eq("valid", int'(valid), int'(rd_ok));
      if (rd_ok) check_eq("buff_out", int'(buff_out), int'(head));
`endif
   endtask

   initial begin
      n_checks = 0; n_pass = 0; m_count = 0; m_err = 1'b0;
      reset_L = 1'b0; write = 1'b0; read = 1'b0; buff_in = '0; error_clr = 1'b0;
      umb_almost_full  = (AW+1)'(AF);
      umb_almost_empty = (AW+1)'(AE);
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_count", int'(data_count), 0);
      check_eq("rst_empty", int'(fifo_empty), 1);
      check_eq("rst_full",  int'(fifo_full),  0);
      check_eq("rst_valid", int'(valid),      0);
      check_eq("rst_error", int'(error),      0);
      check_eq("rst_out",   int'(buff_out),   0);
      check_eq("rst_afull", int'(almost_full), 0);
      @(negedge clk);
      reset_L = 1'b1;

      // Reset mid-burst: 5 pushes, one pop, then an asynchronous pulse between edges
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, DW'(8'h30 + i), 1'b0);
      cycle(1'b0, 1'b1, 6'h00, 1'b0);
      #1 reset_L = 1'b0;
      #1;
      check_eq("midrst_count", int'(data_count), 0);
      check_eq("midrst_empty", int'(fifo_empty), 1);
      check_eq("midrst_valid", int'(valid),      0);
      check_eq("midrst_error", int'(error),      0);
      #1 reset_L = 1'b1;
      m_count = 0; m_err = 1'b0; sb_q.delete();
      cycle(1'b0, 1'b1, 6'h00, 1'b0);
      check_eq("underflow_after_rst", int'(error), 1);
      cycle(1'b0, 1'b0, 6'h00, 1'b1);

      // Fill, overflow, clear
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, DW'(3 + i), 1'b0);
      check_eq("fill_full",  int'(fifo_full),  1);
      check_eq("fill_count", int'(data_count), 8);
      cycle(1'b1, 1'b0, 6'h0B, 1'b0);
      check_eq("ovf_error", int'(error),      1);
      check_eq("ovf_count", int'(data_count), 8);
      cycle(1'b0, 1'b0, 6'h00, 1'b1);
      check_eq("ovf_clr", int'(error), 0);

      // Drain 8 words, then a 9th pop underflows
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 6'h00, 1'b0);
      check_eq("drain_empty", int'(fifo_empty), 1);
      cycle(1'b0, 1'b1, 6'h00, 1'b0);
      check_eq("drain_underflow", int'(error), 1);
      cycle(1'b0, 1'b0, 6'h00, 1'b1);

      // Simultaneous push/pop at full and at count 3 after pointer wrap
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, DW'(8'h10 + i), 1'b0);
      cycle(1'b1, 1'b1, 6'h20, 1'b0);
      check_eq("simul_full_count", int'(data_count), 8);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 6'h00, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, DW'(8'h21 + i), 1'b0);
      check_eq("simul_3_count", int'(data_count), 3);
      check_eq("simul_3_error", int'(error),      0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 6'h00, 1'b0);

      // Random traffic against the scoreboard
      for (int i = 0; i < 400; i++)
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               DW'($urandom), 1'($urandom_range(0, 7) == 0));

`ifdef FIFO_FWFT_EN
      while (m_count != 0) cycle(1'b0, 1'b1, 6'h00, 1'b0);
      cycle(1'b1, 1'b0, 6'h15, 1'b0);
      check_eq("fwft_data",  int'(buff_out), 'h15);
      check_eq("fwft_valid", int'(valid),    1);
      cycle(1'b0, 1'b1, 6'h00, 1'b0);
      check_eq("fwft_ack", int'(valid), 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
